song_sequencer: RTL and testbench
=================================

# song_sequencer

Parametrised multi-voice song player. Walks a song memory of packed note entries `{advance, note, duration, meta}` and groups consecutive entries into chords. It assigns chord members to voice channels and holds each chord for its duration in beat ticks. Sits between the song ROM and the per-voice note players, replacing direct fixed-width ROM stepping with song select, pause, chord staging and end-of-song handling.

## Interface
- `ADDR_W`, 7, entry address bits per song; depth is 2^ADDR_W.
- `SONG_W`, 2, song select bits; 2^SONG_W songs.
- `NUM_VOICES`, 3, voice channels, range 1..8.
- `NOTE_W`, 6, note field width; note 0 means rest/silence.
- `DUR_W`, 6, duration field width, in beats.
- `META_W`, 3, per-note metadata width, passed through.
- Entry width is 1+NOTE_W+DUR_W+META_W (16 at defaults). MSB is `advance`, then note, duration, meta.

Ports:
- `clk`  in  1  single clock.
- `reset`  in  1  asynchronous, active-high.
- `play`  in  1  level; 1 runs, 0 pauses.
- `song_sel`  in  SONG_W  song to start on `new_song`.
- `new_song`  in  1  one-cycle pulse; restart at entry 0 of `song_sel`.
- `beat`  in  1  one-cycle tempo tick.
- `rom_addr`  out  SONG_W+ADDR_W  registered, `{song, ptr}`.
- `rom_data`  in  entry width  valid one cycle after `rom_addr` changes (registered ROM).
- `voice_note`  out  NUM_VOICES*NOTE_W  voice v at `[v*NOTE_W +: NOTE_W]`.
- `voice_meta`  out  NUM_VOICES*META_W  same packing.
- `voice_load`  out  NUM_VOICES  one-cycle pulse, all bits together.
- `song_done`  out  1  see Configuration.
- `voice_ovf`  out  1  sticky; a chord had more than NUM_VOICES entries.

## Operation
- Reset values: all outputs 0, state IDLE, ptr 0, song 0, staging cleared.
- FSM states: IDLE, FETCH, LATCH, COMMIT, HOLD, DONE. Each state lasts at least one cycle.
- IDLE: when `play`=1, go to FETCH.
- FETCH: drive `rom_addr`={song, ptr}. If `play`=0, stay; otherwise go to LATCH.
- LATCH: capture `rom_data` into staging slot `slot`, then increment `slot`.
  - If `slot` ≥ NUM_VOICES, drop the entry and set `voice_ovf`.
  - If `advance`=0: ptr+1, go to FETCH.
  - If `advance`=1: go to COMMIT. The duration comes from this entry.
- COMMIT:
  - Copy staging to `voice_note`/`voice_meta`; unfilled slots load note 0 and meta 0.
  - Pulse `voice_load` on all bits.
  - Load `remain` = duration, clear `slot`, go to HOLD.
- HOLD:
  - If `remain`=0, exit.
  - Otherwise decrement on `beat` while `play`=1. A `beat` arriving while `play`=0 is ignored.
  - Exit when ptr < 2^ADDR_W−1: ptr+1, go to FETCH.
  - Exit when ptr = 2^ADDR_W−1: end-of-song handling (Configuration).
- Duration 0 advances immediately, with no beat consumed.
- A `beat` in COMMIT is ignored.
- Outputs hold their last values between commits.
- `new_song` has priority over everything, in any state:
  - Latch `song_sel`, ptr=0, clear `slot`/staging/`voice_ovf`/`remain`.
  - Go to FETCH if `play`=1, else IDLE.
  - Voice outputs are not changed until the next commit.
- Pause during FETCH/HOLD freezes the state; `rom_addr` is held.
- LATCH and COMMIT always complete, since the ROM data is already in flight.

## Timing
- Latency, `play` rise to first load: `play` sampled high at edge t; FETCH during t+1; LATCH t+2; `voice_load` high during t+3.
- A chord of k entries (k ≤ NUM_VOICES) costs 2k+1 cycles from its first FETCH to `voice_load`.
- The d-th counted `beat` of a chord is followed by FETCH in the next cycle.
- Asynchronous `reset` mid-song forces the reset values immediately.

## Configuration
- `SONG_SEQUENCER_LOOP_EN` defined:
  - At end of song, ptr wraps to 0 and `song_done` pulses for one cycle in the wrap cycle.
  - The FSM goes to FETCH; the song loops forever.
- Not defined:
  - At end of song, go to DONE.
  - On entry to DONE, pulse `voice_load` with all notes/meta 0 (silence).
  - `song_done` is held at 1 in DONE.
  - Leave DONE only via `new_song` or `reset`.

## Structure
- Shared package `song_pkg` holds:
  - The entry-field constants: widths, advance bit index, field offsets.
  - The state enum.
  - A `REST_NOTE` = 0 constant.
- One sub-module, `chord_stage`: NUM_VOICES staging registers, slot counter, overflow flag, with clear/capture/commit controls. The FSM, pointer and beat counter stay in `song_sequencer`.

## Test plan
- Reset, then `play`=1; ROM [0]={1,49,2,7}. Expect `voice_load`=3'b111 exactly 3 cycles after `play`, voice0=49/meta7, voices 1–2=0. Next FETCH only after the 2nd `beat`.
- Chord [0]={0,52,..}, [1]={0,56,..}, [2]={1,59,4,3} → one load with voices 52/56/59, 7 cycles after the first FETCH, held for 4 beats.
- 4-entry chord with NUM_VOICES=3 → fourth entry dropped, `voice_ovf`=1; `new_song` clears it.
- Drop `play` mid-HOLD with remain=3, issue 5 beats, raise `play`, then 3 beats → advance after exactly the 3rd beat after resume.
- Last entry (ptr 127) with duration 1: with LOOP_EN, `song_done` pulses one cycle and `rom_addr` goes to {song,0}. Without it, a silence load occurs and `song_done` stays at 1.
- `new_song` with `song_sel`=2 during HOLD → next `rom_addr`={2,0}. Assert `reset` mid-LATCH → all outputs 0 at once.

Source files
------------

// File: rtl/song_pkg.sv
// song_pkg: shared entry-field layout, FSM state encoding and rest note
// for the song sequencer. Entry layout (MSB first): {advance, note, duration, meta}.
package song_pkg;

  // Default field widths; modules take these as parameter defaults.
  localparam int DEF_ADDR_W     = 7;
  localparam int DEF_SONG_W     = 2;
  localparam int DEF_NUM_VOICES = 3;
  localparam int DEF_NOTE_W     = 6;
  localparam int DEF_DUR_W      = 6;
  localparam int DEF_META_W     = 3;

  // Meta always sits at the bottom of the entry.
  localparam int META_LSB = 0;

  // Note value that means silence.
  localparam int REST_NOTE = 0;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LATCH,
    S_COMMIT,
    S_HOLD,
    S_DONE
  } state_t;

  function automatic int entry_width(input int note_w, input int dur_w, input int meta_w);
    return 1 + note_w + dur_w + meta_w;
  endfunction

  function automatic int dur_lsb(input int meta_w);
    return meta_w;
  endfunction

  function automatic int note_lsb(input int dur_w, input int meta_w);
    return dur_w + meta_w;
  endfunction

  function automatic int adv_bit(input int note_w, input int dur_w, input int meta_w);
    return entry_width(note_w, dur_w, meta_w) - 1;
  endfunction

endpackage

// File: rtl/song_sequencer_chord_stage.sv
// chord_stage: per-voice staging registers for one chord, the fill-slot
// counter and the sticky overflow flag. The view outputs merge an entry being
// captured this cycle so the parent can commit a chord on its closing entry.
module chord_stage
  import song_pkg::*;
#(
  parameter int NUM_VOICES = DEF_NUM_VOICES,
  parameter int NOTE_W     = DEF_NOTE_W,
  parameter int META_W     = DEF_META_W
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         i_clear_all,
  input  logic                         i_commit,
  input  logic                         i_capture,
  input  logic [NOTE_W-1:0]            i_note,
  input  logic [META_W-1:0]            i_meta,
  output logic [NUM_VOICES*NOTE_W-1:0] o_view_note,
  output logic [NUM_VOICES*META_W-1:0] o_view_meta,
  output logic                         o_ovf
);

  localparam int SLOT_W = $clog2(NUM_VOICES + 1);
  localparam logic [SLOT_W-1:0] SLOT_FULL = SLOT_W'(NUM_VOICES);

  logic [SLOT_W-1:0] r_slot;
  logic              r_ovf;

  // Slot counter saturates at NUM_VOICES; extra entries only raise overflow.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_slot <= '0;
      r_ovf  <= 1'b0;
    end else if (i_clear_all) begin
      r_slot <= '0;
      r_ovf  <= 1'b0;
    end else if (i_commit) begin
      r_slot <= '0;
    end else if (i_capture) begin
      if (r_slot == SLOT_FULL) begin
        r_ovf <= 1'b1;
      end else begin
        r_slot <= r_slot + 1'b1;
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_VOICES; gi++) begin : g_slot
      logic [NOTE_W-1:0] r_note;
      logic [META_W-1:0] r_meta;
      logic              w_hit;

      assign w_hit = i_capture && (r_slot == SLOT_W'(gi));

      // Slot register: cleared after every commit so unfilled voices go silent.
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          r_note <= NOTE_W'(REST_NOTE);
          r_meta <= '0;
        end else if (i_clear_all || i_commit) begin
          r_note <= NOTE_W'(REST_NOTE);
          r_meta <= '0;
        end else if (w_hit) begin
          r_note <= i_note;
          r_meta <= i_meta;
        end
      end

      assign o_view_note[gi*NOTE_W +: NOTE_W] = w_hit ? i_note : r_note;
      assign o_view_meta[gi*META_W +: META_W] = w_hit ? i_meta : r_meta;
    end
  endgenerate

  assign o_ovf = r_ovf;

endmodule

// File: rtl/song_sequencer.sv
// song_sequencer: walks a song ROM, groups entries into chords, loads them
// onto voice channels and holds each chord for its duration in beat ticks.
// Build option: define SONG_SEQUENCER_LOOP_EN to loop songs forever instead
// of stopping in DONE with a silence load.
module song_sequencer
  import song_pkg::*;
#(
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int SONG_W     = DEF_SONG_W,
  parameter int NUM_VOICES = DEF_NUM_VOICES,
  parameter int NOTE_W     = DEF_NOTE_W,
  parameter int DUR_W      = DEF_DUR_W,
  parameter int META_W     = DEF_META_W,
  localparam int ENTRY_W   = entry_width(NOTE_W, DUR_W, META_W)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         play,
  input  logic [SONG_W-1:0]            song_sel,
  input  logic                         new_song,
  input  logic                         beat,
  output logic [SONG_W+ADDR_W-1:0]     rom_addr,
  input  logic [ENTRY_W-1:0]           rom_data,
  output logic [NUM_VOICES*NOTE_W-1:0] voice_note,
  output logic [NUM_VOICES*META_W-1:0] voice_meta,
  output logic [NUM_VOICES-1:0]        voice_load,
  output logic                         song_done,
  output logic                         voice_ovf
);

  localparam int ADV_BIT  = adv_bit(NOTE_W, DUR_W, META_W);
  localparam int NOTE_LSB = note_lsb(DUR_W, META_W);
  localparam int DUR_LSB  = dur_lsb(META_W);
  localparam logic [ADDR_W-1:0] PTR_LAST = '1;

  state_t                      r_state;
  logic [SONG_W-1:0]           r_song;
  logic [ADDR_W-1:0]           r_ptr;
  logic [DUR_W-1:0]            r_remain;
  logic [SONG_W+ADDR_W-1:0]    r_rom_addr;
  logic [NUM_VOICES*NOTE_W-1:0] r_voice_note;
  logic [NUM_VOICES*META_W-1:0] r_voice_meta;
  logic [NUM_VOICES-1:0]       r_voice_load;
  logic                        r_song_done;

  logic                        w_adv;
  logic [NOTE_W-1:0]           w_note;
  logic [DUR_W-1:0]            w_dur;
  logic [META_W-1:0]           w_meta;
  logic [ADDR_W-1:0]           w_ptr_inc;
  logic                        w_capture;
  logic                        w_commit;
  logic                        w_hold_exit;
  logic [NUM_VOICES*NOTE_W-1:0] w_view_note;
  logic [NUM_VOICES*META_W-1:0] w_view_meta;

  assign w_adv     = rom_data[ADV_BIT];
  assign w_note    = rom_data[NOTE_LSB +: NOTE_W];
  assign w_dur     = rom_data[DUR_LSB +: DUR_W];
  assign w_meta    = rom_data[META_LSB +: META_W];
  assign w_ptr_inc = r_ptr + 1'b1;

  // new_song overrides any staging activity in the same cycle.
  assign w_capture = (r_state == S_LATCH) && !new_song;
  assign w_commit  = (r_state == S_COMMIT) && !new_song;

  // Hold ends on an empty counter or on the beat that would empty it, so the
  // next FETCH follows the final beat directly.
  assign w_hold_exit = play && ((r_remain == '0) || (beat && (r_remain == DUR_W'(1))));

  chord_stage #(
    .NUM_VOICES (NUM_VOICES),
    .NOTE_W     (NOTE_W),
    .META_W     (META_W)
  ) u_chord_stage (
    .clk         (clk),
    .reset       (reset),
    .i_clear_all (new_song),
    .i_commit    (w_commit),
    .i_capture   (w_capture),
    .i_note      (w_note),
    .i_meta      (w_meta),
    .o_view_note (w_view_note),
    .o_view_meta (w_view_meta),
    .o_ovf       (voice_ovf)
  );

  // Sequencer FSM with registered ROM address and voice outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_song       <= '0;
      r_ptr        <= '0;
      r_remain     <= '0;
      r_rom_addr   <= '0;
      r_voice_note <= '0;
      r_voice_meta <= '0;
      r_voice_load <= '0;
      r_song_done  <= 1'b0;
    end else begin
      r_voice_load <= '0;
`ifdef SONG_SEQUENCER_LOOP_EN
      r_song_done  <= 1'b0;
`endif
      if (new_song) begin
        r_song      <= song_sel;
        r_ptr       <= '0;
        r_remain    <= '0;
        r_song_done <= 1'b0;
        if (play) begin
          r_state    <= S_FETCH;
          r_rom_addr <= {song_sel, {ADDR_W{1'b0}}};
        end else begin
          r_state    <= S_IDLE;
        end
      end else begin
        case (r_state)
          S_IDLE: begin
            if (play) begin
              r_state    <= S_FETCH;
              r_rom_addr <= {r_song, r_ptr};
            end
          end
          S_FETCH: begin
            if (play) begin
              r_state <= S_LATCH;
            end
          end
          S_LATCH: begin
            if (w_adv) begin
              // Closing entry: publish the chord now so the load pulse
              // coincides with the COMMIT cycle.
              r_state      <= S_COMMIT;
              r_remain     <= w_dur;
              r_voice_note <= w_view_note;
              r_voice_meta <= w_view_meta;
              r_voice_load <= '1;
            end else begin
              r_state    <= S_FETCH;
              r_ptr      <= w_ptr_inc;
              r_rom_addr <= {r_song, w_ptr_inc};
            end
          end
          S_COMMIT: begin
            r_state <= S_HOLD;
          end
          S_HOLD: begin
            if (w_hold_exit) begin
              r_remain <= '0;
              if (r_ptr != PTR_LAST) begin
                r_state    <= S_FETCH;
                r_ptr      <= w_ptr_inc;
                r_rom_addr <= {r_song, w_ptr_inc};
              end else begin
`ifdef SONG_SEQUENCER_LOOP_EN
                r_state     <= S_FETCH;
                r_ptr       <= '0;
                r_rom_addr  <= {r_song, {ADDR_W{1'b0}}};
                r_song_done <= 1'b1;
`else
                r_state      <= S_DONE;
                r_voice_note <= {NUM_VOICES{NOTE_W'(REST_NOTE)}};
                r_voice_meta <= '0;
                r_voice_load <= '1;
                r_song_done  <= 1'b1;
`endif
              end
            end else if (play && beat) begin
              r_remain <= r_remain - 1'b1;
            end
          end
          S_DONE: begin
            r_state <= S_DONE;
          end
          default: begin
            r_state <= S_IDLE;
          end
        endcase
      end
    end
  end

  assign rom_addr   = r_rom_addr;
  assign voice_note = r_voice_note;
  assign voice_meta = r_voice_meta;
  assign voice_load = r_voice_load;
  assign song_done  = r_song_done;

endmodule

// File: tb/tb_song_sequencer.sv
// Directed bench for song_sequencer at default parameters. A registered ROM
// model holds song 0 (chords, overflow, pause, zero duration), song 1 (full
// length for end-of-song) and song 2 (song switching).
module tb_song_sequencer;

  logic        clk;
  logic        reset;
  logic        play;
  logic [1:0]  song_sel;
  logic        new_song;
  logic        beat;
  logic [8:0]  rom_addr;
  logic [15:0] rom_data;
  logic [17:0] voice_note;
  logic [8:0]  voice_meta;
  logic [2:0]  voice_load;
  logic        song_done;
  logic        voice_ovf;

  logic [15:0] rom [0:511];

  int n_checks;
  int n_fail;

  song_sequencer dut (
    .clk        (clk),
    .reset      (reset),
    .play       (play),
    .song_sel   (song_sel),
    .new_song   (new_song),
    .beat       (beat),
    .rom_addr   (rom_addr),
    .rom_data   (rom_data),
    .voice_note (voice_note),
    .voice_meta (voice_meta),
    .voice_load (voice_load),
    .song_done  (song_done),
    .voice_ovf  (voice_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Registered ROM: data follows the address by one clock.
  always @(posedge clk) rom_data <= rom[rom_addr];

  function automatic logic [15:0] ent(input int adv, input int note, input int dur, input int meta);
    return {adv[0], note[5:0], dur[5:0], meta[2:0]};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, got);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic pulse_beat();
    beat = 1'b1;
    step();
    beat = 1'b0;
    step();
  endtask

  // Advance until the next voice_load pulse, with a cycle budget.
  task automatic wait_load(input string tag);
    int n;
    n = 0;
    step();
    while (voice_load == 3'b000 && n < 300) begin
      step();
      n++;
    end
    check({tag, "_load_seen"}, {29'd0, voice_load}, 32'h7);
  endtask

  initial begin
    int n;
    n_checks = 0;
    n_fail   = 0;
    for (int i = 0; i < 512; i++) rom[i] = 16'h0000;
    // Song 0
    rom[0]  = ent(1, 49, 2, 7);
    rom[1]  = ent(0, 52, 0, 1);
    rom[2]  = ent(0, 56, 0, 2);
    rom[3]  = ent(1, 59, 4, 3);
    rom[4]  = ent(0, 10, 0, 1);
    rom[5]  = ent(0, 11, 0, 2);
    rom[6]  = ent(0, 12, 0, 3);
    rom[7]  = ent(1, 13, 1, 4);
    rom[8]  = ent(1, 20, 3, 5);
    rom[9]  = ent(1, 21, 0, 6);
    rom[10] = ent(1, 22, 2, 0);
    // Song 1: zero-duration single notes, last entry lasts one beat
    for (int i = 128; i < 255; i++) rom[i] = ent(1, 30, 0, 0);
    rom[255] = ent(1, 40, 1, 2);
    // Song 2
    rom[256] = ent(1, 33, 5, 1);

    reset = 1'b1; play = 1'b0; song_sel = 2'd0; new_song = 1'b0; beat = 1'b0;
    step(); step();
    check("rst_rom_addr", {23'd0, rom_addr}, 32'd0);
    check("rst_voice_note", {14'd0, voice_note}, 32'd0);
    check("rst_voice_load", {29'd0, voice_load}, 32'd0);
    check("rst_song_done", {31'd0, song_done}, 32'd0);
    check("rst_voice_ovf", {31'd0, voice_ovf}, 32'd0);
    reset = 1'b0;
    step(); step();

    // Single-note chord: load exactly 3 cycles after play goes high.
    play = 1'b1;
    step();
    check("lat_fetch_load", {29'd0, voice_load}, 32'd0);
    step();
    check("lat_latch_load", {29'd0, voice_load}, 32'd0);
    step();
    check("lat_load", {29'd0, voice_load}, 32'h7);
    check("lat_note", {14'd0, voice_note}, {14'd0, 6'd0, 6'd0, 6'd49});
    check("lat_meta", {23'd0, voice_meta}, {23'd0, 3'd0, 3'd0, 3'd7});
    step();
    check("lat_load_pulse", {29'd0, voice_load}, 32'd0);
    beat = 1'b1; step(); beat = 1'b0;
    check("hold_after_beat1", {23'd0, rom_addr}, 32'd0);
    step(); step();
    beat = 1'b1; step(); beat = 1'b0;
    check("fetch_after_beat2", {23'd0, rom_addr}, 32'd1);

    // Three-entry chord: load in the 7th cycle counting the first FETCH.
    repeat (5) step();
    check("chord_pre_load", {29'd0, voice_load}, 32'd0);
    step();
    check("chord_load", {29'd0, voice_load}, 32'h7);
    check("chord_note", {14'd0, voice_note}, {14'd0, 6'd59, 6'd56, 6'd52});
    check("chord_meta", {23'd0, voice_meta}, {23'd0, 3'd3, 3'd2, 3'd1});
    // This beat lands in COMMIT and must be ignored.
    beat = 1'b1; step(); beat = 1'b0;
    repeat (3) pulse_beat();
    check("chord_hold_3beats", {23'd0, rom_addr}, 32'd3);
    beat = 1'b1; step(); beat = 1'b0;
    check("chord_advance_4th", {23'd0, rom_addr}, 32'd4);

    // Four entries into three voices: last one dropped, overflow set.
    wait_load("ovf");
    check("ovf_note", {14'd0, voice_note}, {14'd0, 6'd12, 6'd11, 6'd10});
    check("ovf_meta", {23'd0, voice_meta}, {23'd0, 3'd3, 3'd2, 3'd1});
    check("ovf_flag", {31'd0, voice_ovf}, 32'd1);
    step();
    beat = 1'b1; step(); beat = 1'b0;
    check("ovf_advance", {23'd0, rom_addr}, 32'd8);

    // Pause mid-hold: beats while paused do not count.
    wait_load("pause");
    check("pause_note", {14'd0, voice_note}, {14'd0, 6'd0, 6'd0, 6'd20});
    check("pause_meta", {23'd0, voice_meta}, {23'd0, 3'd0, 3'd0, 3'd5});
    play = 1'b0;
    step();
    repeat (5) pulse_beat();
    check("pause_frozen", {23'd0, rom_addr}, 32'd8);
    play = 1'b1;
    repeat (2) pulse_beat();
    check("resume_2beats", {23'd0, rom_addr}, 32'd8);
    beat = 1'b1; step(); beat = 1'b0;
    check("resume_3rd_beat", {23'd0, rom_addr}, 32'd9);

    // Zero duration: advances without a beat.
    wait_load("dur0");
    check("dur0_note", {14'd0, voice_note}, {14'd0, 6'd0, 6'd0, 6'd21});
    step(); step();
    check("dur0_advance", {23'd0, rom_addr}, 32'd10);

    // new_song during HOLD.
    wait_load("pre_switch");
    check("ovf_sticky", {31'd0, voice_ovf}, 32'd1);
    step();
    song_sel = 2'd2; new_song = 1'b1; step(); new_song = 1'b0;
    check("switch_rom_addr", {23'd0, rom_addr}, 32'h100);
    check("switch_ovf_clr", {31'd0, voice_ovf}, 32'd0);
    check("switch_note_kept", {14'd0, voice_note}, {14'd0, 6'd0, 6'd0, 6'd22});
    wait_load("song2");
    check("song2_note", {14'd0, voice_note}, {14'd0, 6'd0, 6'd0, 6'd33});
    check("song2_meta", {23'd0, voice_meta}, {23'd0, 3'd0, 3'd0, 3'd1});

    // Asynchronous reset while in LATCH.
    new_song = 1'b1; step(); new_song = 1'b0;
    step();
    #1 reset = 1'b1;
    #1;
    check("arst_rom_addr", {23'd0, rom_addr}, 32'd0);
    check("arst_note", {14'd0, voice_note}, 32'd0);
    check("arst_meta", {23'd0, voice_meta}, 32'd0);
    step();
    reset = 1'b0;

    // End of song 1.
    song_sel = 2'd1; new_song = 1'b1; step(); new_song = 1'b0;
    n = 0;
    while (rom_addr != 9'h0FF && n < 2000) begin
      step();
      n++;
    end
    check("eos_reached_last", {23'd0, rom_addr}, 32'h0FF);
    wait_load("eos_last");
    check("eos_last_note", {14'd0, voice_note}, {14'd0, 6'd0, 6'd0, 6'd40});
    step();
    beat = 1'b1; step(); beat = 1'b0;
`ifdef SONG_SEQUENCER_LOOP_EN
    check("loop_done_pulse", {31'd0, song_done}, 32'd1);
    check("loop_rom_addr", {23'd0, rom_addr}, 32'h080);
    step();
    check("loop_done_clear", {31'd0, song_done}, 32'd0);
`else
    check("done_silence_load", {29'd0, voice_load}, 32'h7);
    check("done_silence_note", {14'd0, voice_note}, 32'd0);
    check("done_silence_meta", {23'd0, voice_meta}, 32'd0);
    check("done_flag", {31'd0, song_done}, 32'd1);
    repeat (3) pulse_beat();
    check("done_flag_held", {31'd0, song_done}, 32'd1);
    check("done_no_load", {29'd0, voice_load}, 32'd0);
    check("done_rom_addr", {23'd0, rom_addr}, 32'h0FF);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
